stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/arm_lp_pkg.sv | 40 ++++
 rtl/ack_timer.sv | 42 ++++
 rtl/stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_stage_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_lp_pkg.sv
// Shared definitions for the ARM-LP control path: sequencer state encoding,
// decoded instruction classes and small classification helpers. The
// instruction controller imports the same package.
package arm_lp_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd7
    } seq_state_t;

    typedef enum logic [2:0] {
        OP_LD      = 3'd0,
        OP_CB      = 3'd1,
        OP_R       = 3'd2,
        OP_ST      = 3'd3,
        OP_I       = 3'd4,
        OP_B       = 3'd5,
        OP_M       = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_type_t;

    // Wide enough for the largest supported timeout (1023 cycles).
    localparam int ACK_TIMER_W = 10;

    // Loads and stores are the only classes that touch the data cache.
    function automatic logic is_mem_op(op_type_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Branch classes retire straight out of EXECUTE with a PC update.
    function automatic logic is_branch_op(op_type_t op);
        return (op == OP_CB) || (op == OP_B);
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Acknowledge wait counter. Counts cycles spent waiting on a cache
// acknowledge and flags expiry in the cycle the count would reach
// TIMEOUT_CYCLES. Expiry does not depend on clear, so the caller may derive
// clear from a next-state that itself depends on expired.
module ack_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    import arm_lp_pkg::*;

    localparam logic [ACK_TIMER_W-1:0] LAST_COUNT = ACK_TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [ACK_TIMER_W-1:0] count_q;
    logic [ACK_TIMER_W-1:0] count_d;

    // Next count: clear wins, otherwise advance on each unacknowledged cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + ACK_TIMER_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = tick && (count_q == LAST_COUNT);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: IDLE -> FETCH -> DECODE ->
// EXECUTE -> [MEMORY] -> [WRITEBACK], with ack timeouts and a sticky FAULT.
// Optional feature macro: PERF_COUNT_EN adds saturating retireCount and
// stallCount outputs.
module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       halt,
    input  logic [2:0] opType,
    input  logic       imemAck,
    input  logic       dmemAck,
    output logic       imemReq,
    output logic       irLoad,
    output logic       dmemReq,
    output logic       regWriteEnable,
    output logic       pcWriteEnable,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0] retireCount,
    output logic [31:0] stallCount
`endif
);
    import arm_lp_pkg::*;

    seq_state_t state_q, state_d;
    op_type_t   op_q, op_d;
    logic       wait_tick;
    logic       timer_clear;
    logic       timer_expired;
    logic       instr_end;

    // A wait cycle is any FETCH/MEMORY cycle whose own acknowledge is absent;
    // acks for the other cache are ignored here by construction.
    assign wait_tick = ((state_q == S_FETCH)  && !imemAck) ||
                       ((state_q == S_MEMORY) && !dmemAck);

    // Every state change restarts the wait count, which covers entry into
    // FETCH (including MEMORY -> FETCH after a store) and into MEMORY.
    assign timer_clear = (state_d != state_q);

    ack_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .tick    (wait_tick),
        .expired (timer_expired)
    );

    // Next-state and strobe decode; strobes come only from the registered
    // state (plus the matching ack), so FAULT and IDLE drive everything low.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        imemReq        = 1'b0;
        irLoad         = 1'b0;
        dmemReq        = 1'b0;
        regWriteEnable = 1'b0;
        pcWriteEnable  = 1'b0;
        instr_end      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    irLoad  = 1'b1;
                    state_d = S_DECODE;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (op_type_t'(opType) == OP_ILLEGAL) begin
                    state_d = S_FAULT;
                end else begin
                    op_d    = op_type_t'(opType);
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_mem_op(op_q)) begin
                    state_d = S_MEMORY;
                end else if (is_branch_op(op_q)) begin
                    pcWriteEnable = 1'b1;
                    instr_end     = 1'b1;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                dmemReq = 1'b1;
                if (dmemAck) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pcWriteEnable = 1'b1;
                        instr_end     = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                regWriteEnable = 1'b1;
                pcWriteEnable  = 1'b1;
                instr_end      = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Instruction boundary: halt is only looked at here.
        if (instr_end) begin
            state_d = halt ? S_IDLE : S_FETCH;
        end
    end

    // State and latched instruction class.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LD;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault = (state_q == S_FAULT);
    assign state = state_q;

`ifdef PERF_COUNT_EN
    logic [31:0] retire_q, retire_d;
    logic [31:0] stall_q, stall_d;

    // Saturating event counters: retired instructions and wait cycles.
    always_comb begin
        retire_d = retire_q;
        stall_d  = stall_q;
        if (instr_end && (retire_q != '1)) begin
            retire_d = retire_q + 32'd1;
        end
        if (wait_tick && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign retireCount = retire_q;
    assign stallCount  = stall_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios followed by randomized
// instructions. Expected per-cycle outputs come from a per-instruction model
// that lays out the stage sequence from the instruction class and ack delays.
module tb_stage_sequencer;

    localparam int TO = 4;

    localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3,
                           SM = 3'd4, SW = 3'd5, SX = 3'd7;
    localparam logic [2:0] LD = 3'd0, CB = 3'd1, R = 3'd2, ST = 3'd3,
                           I  = 3'd4, B  = 3'd5, M = 3'd6, ILL = 3'd7;

    logic       clock = 1'b0;
    logic       reset, start, halt, imemAck, dmemAck;
    logic [2:0] opType;
    logic       imemReq, irLoad, dmemReq, regWriteEnable, pcWriteEnable, busy, fault;
    logic [2:0] state;
`ifdef PERF_COUNT_EN
    logic [31:0] retireCount, stallCount;
`endif

    int total = 0;
    int bad   = 0;
    bit at_idle;
    int m_retire;
    int m_stall;
    bit flt;

    stage_sequencer #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .halt           (halt),
        .opType         (opType),
        .imemAck        (imemAck),
        .dmemAck        (dmemAck),
        .imemReq        (imemReq),
        .irLoad         (irLoad),
        .dmemReq        (dmemReq),
        .regWriteEnable (regWriteEnable),
        .pcWriteEnable  (pcWriteEnable),
        .busy           (busy),
        .fault          (fault),
        .state          (state)
`ifdef PERF_COUNT_EN
        ,
        .retireCount    (retireCount),
        .stallCount     (stallCount)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic [9:0] expv(input logic [2:0] s, input bit ireq, input bit irl,
                                        input bit dreq, input bit rw, input bit pw);
        return {s, ireq, irl, dreq, rw, pw, (s != SI) && (s != SX), (s == SX)};
    endfunction

    function automatic logic [9:0] obsv();
        return {state, imemReq, irLoad, dmemReq, regWriteEnable, pcWriteEnable, busy, fault};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs.
    task automatic cyc(input string tag, input bit ia, input bit da, input logic [2:0] op,
                       input bit hl, input bit sti, input logic [2:0] s,
                       input bit ireq, input bit irl, input bit dreq, input bit rw, input bit pw);
        @(negedge clock);
        imemAck = ia;
        dmemAck = da;
        opType  = op;
        halt    = hl;
        start   = sti;
        #1;
        chk(tag, 32'(obsv()), 32'(expv(s, ireq, irl, dreq, rw, pw)));
    endtask

    task automatic end_instr(input bit hl);
        m_retire++;
        at_idle = hl;
`ifdef PERF_COUNT_EN
        @(posedge clock);
        #1;
        chk("retire_count", retireCount, 32'(m_retire));
        chk("stall_count", stallCount, 32'(m_stall));
`endif
    endtask

    // One instruction: df/dm are the number of wait cycles before the fetch
    // and data acks; a delay of TO or more means the ack never comes.
    task automatic run_instr(input logic [2:0] op, input int df, input int dm, input bit hl,
                             output bit faulted);
        faulted = 1'b0;
        if (at_idle) begin
            cyc("idle_wait",  rb(), rb(), rop(), rb(), 1'b0, SI, 0, 0, 0, 0, 0);
            cyc("idle_start", rb(), rb(), rop(), rb(), 1'b1, SI, 0, 0, 0, 0, 0);
            at_idle = 1'b0;
        end
        for (int k = 0; k < TO; k++) begin
            if (k == df) begin
                cyc("fetch_ack", 1'b1, rb(), rop(), rb(), rb(), SF, 1, 1, 0, 0, 0);
                break;
            end
            cyc("fetch_wait", 1'b0, rb(), rop(), rb(), rb(), SF, 1, 0, 0, 0, 0);
            m_stall++;
        end
        if (df >= TO) begin
            faulted = 1'b1;
            return;
        end
        cyc("decode", rb(), rb(), op, rb(), rb(), SD, 0, 0, 0, 0, 0);
        if (op == ILL) begin
            faulted = 1'b1;
            return;
        end
        if (op == CB || op == B) begin
            cyc("exec_branch", rb(), rb(), rop(), hl, rb(), SE, 0, 0, 0, 0, 1);
            end_instr(hl);
            return;
        end
        cyc("execute", rb(), rb(), rop(), rb(), rb(), SE, 0, 0, 0, 0, 0);
        if (op == LD || op == ST) begin
            for (int k = 0; k < TO; k++) begin
                if (k == dm) begin
                    cyc("mem_ack", rb(), 1'b1, rop(), (op == ST) ? hl : rb(), rb(), SM,
                        0, 0, 1, 0, (op == ST));
                    break;
                end
                cyc("mem_wait", rb(), 1'b0, rop(), rb(), rb(), SM, 0, 0, 1, 0, 0);
                m_stall++;
            end
            if (dm >= TO) begin
                faulted = 1'b1;
                return;
            end
            if (op == ST) begin
                end_instr(hl);
                return;
            end
        end
        cyc("writeback", rb(), rb(), rop(), hl, rb(), SW, 0, 0, 0, 1, 1);
        end_instr(hl);
    endtask

    task automatic fault_hold(input int n);
        for (int k = 0; k < n; k++) begin
            cyc("fault_hold", rb(), rb(), rop(), rb(), rb(), SX, 0, 0, 0, 0, 0);
        end
`ifdef PERF_COUNT_EN
        chk("fault_stall_count", stallCount, 32'(m_stall));
        chk("fault_retire_count", retireCount, 32'(m_retire));
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        start   = 1'b0;
        halt    = 1'b0;
        imemAck = rb();
        dmemAck = rb();
        opType  = rop();
        #1;
        chk("reset_outputs", 32'(obsv()), 32'(expv(SI, 0, 0, 0, 0, 0)));
        m_retire = 0;
        m_stall  = 0;
        at_idle  = 1'b1;
`ifdef PERF_COUNT_EN
        chk("reset_retire", retireCount, 32'd0);
        chk("reset_stall", stallCount, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        halt     = 1'b0;
        imemAck  = 1'b0;
        dmemAck  = 1'b0;
        opType   = 3'd0;
        m_retire = 0;
        m_stall  = 0;
        at_idle  = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("por_outputs", 32'(obsv()), 32'(expv(SI, 0, 0, 0, 0, 0)));
`ifdef PERF_COUNT_EN
        chk("por_retire", retireCount, 32'd0);
        chk("por_stall", stallCount, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // Register-class instruction, zero-wait acks.
        run_instr(R, 0, 0, 1'b0, flt);
        // Load with three missing data acks: ack lands on the timeout boundary.
        run_instr(LD, 0, 3, 1'b0, flt);
        // Fetch ack on the last cycle before timeout.
        run_instr(M, 3, 0, 1'b0, flt);
        run_instr(I, 1, 0, 1'b0, flt);
        run_instr(CB, 0, 0, 1'b0, flt);
        // Store then branch with halt at the branch boundary.
        run_instr(ST, 0, 0, 1'b0, flt);
        run_instr(B, 0, 0, 1'b1, flt);
        cyc("idle_after_halt", rb(), rb(), rop(), rb(), 1'b0, SI, 0, 0, 0, 0, 0);

        // Fetch timeout: imemAck never arrives.
        run_instr(R, 99, 0, 1'b0, flt);
        fault_hold(20);
        do_reset();

        // Illegal opcode at DECODE, then reset out of FAULT.
        run_instr(ILL, 0, 0, 1'b0, flt);
        fault_hold(3);
        do_reset();

        // Data timeout on a store.
        run_instr(ST, 0, 99, 1'b0, flt);
        fault_hold(3);
        do_reset();

        // Asynchronous reset in the middle of a MEMORY wait.
        cyc("idle_wait",  rb(), rb(), rop(), rb(), 1'b0, SI, 0, 0, 0, 0, 0);
        cyc("idle_start", rb(), rb(), rop(), rb(), 1'b1, SI, 0, 0, 0, 0, 0);
        cyc("fetch_ack",  1'b1, rb(), rop(), rb(), rb(), SF, 1, 1, 0, 0, 0);
        cyc("decode",     rb(), rb(), LD, rb(), rb(), SD, 0, 0, 0, 0, 0);
        cyc("execute",    rb(), rb(), rop(), rb(), rb(), SE, 0, 0, 0, 0, 0);
        cyc("mem_wait",   rb(), 1'b0, rop(), rb(), rb(), SM, 0, 0, 1, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(obsv()), 32'(expv(SI, 0, 0, 0, 0, 0)));
`ifdef PERF_COUNT_EN
        chk("async_reset_retire", retireCount, 32'd0);
        chk("async_reset_stall", stallCount, 32'd0);
`endif
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        m_retire = 0;
        m_stall  = 0;
        at_idle  = 1'b1;

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            int         df;
            int         dm;
            op = rop();
            df = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
            dm = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
            run_instr(op, df, dm, rb(), flt);
            if (flt) begin
                fault_hold(2);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
